// File: rtl/fp16_mul_result_buffer.sv
// Result FIFO behind the FP16 Vedic multiplier. It buffers each product with its
// exception/overflow/underflow flags and keeps sticky flags plus saturating event counters.
module fp16_mul_result_buffer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [15:0]                in_result,
    input  logic                       in_exception,
    input  logic                       in_overflow,
    input  logic                       in_underflow,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [15:0]                out_result,
    output logic [2:0]                 out_flags,
    output logic [2:0]                 sticky_flags,
    input  logic                       clr_sticky,
    output logic [CNT_W-1:0]           cnt_total,
    output logic [CNT_W-1:0]           cnt_exception,
    output logic [CNT_W-1:0]           cnt_overflow,
    output logic [CNT_W-1:0]           cnt_underflow,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [18:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [18:0]      head;
    logic [2:0]       in_flags;
    logic             push;
    logic             pop;

    assign in_ready  = (level != FULL_LVL);
    assign out_valid = (level != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign in_flags  = {in_exception, in_overflow, in_underflow};
    assign head      = mem[rd_ptr];

    // Empty reads as zero so stale storage never leaks onto the output.
    assign out_result = out_valid ? head[18:3] : 16'h0000;
    assign out_flags  = out_valid ? head[2:0]  : 3'b000;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
        return (en && (c != '1)) ? c + CNT_W'(1) : c;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {in_result, in_flags};
    end

    // A clear on the same edge as a push wins; the pushed entry still goes into the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_flags  <= '0;
            cnt_total     <= '0;
            cnt_exception <= '0;
            cnt_overflow  <= '0;
            cnt_underflow <= '0;
        end else if (clr_sticky) begin
            sticky_flags  <= '0;
            cnt_total     <= '0;
            cnt_exception <= '0;
            cnt_overflow  <= '0;
            cnt_underflow <= '0;
        end else if (push) begin
            sticky_flags  <= sticky_flags | in_flags;
            cnt_total     <= sat_inc(cnt_total, 1'b1);
            cnt_exception <= sat_inc(cnt_exception, in_exception);
            cnt_overflow  <= sat_inc(cnt_overflow, in_overflow);
            cnt_underflow <= sat_inc(cnt_underflow, in_underflow);
        end
    end

endmodule

// File: doc/fp16_mul_result_buffer.md
Name: fp16_mul_result_buffer

Overview:
- Sits directly downstream of the FP16 Vedic multiplier.
- Captures each product and its Exception/Overflow/Underflow flags through a valid/ready handshake into a small register FIFO.
- Drains entries to the consumer with a matching handshake.
- Keeps sticky status flags and saturating event counters readable by the surrounding control logic.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, 16, width of each event counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  product and flags present on the inputs.
- in_ready  out  1  buffer can accept; equals !full.
- in_result  in  16  FP16 product from the multiplier.
- in_exception  in  1  multiplier Exception flag.
- in_overflow  in  1  multiplier Overflow flag.
- in_underflow  in  1  multiplier Underflow flag.
- out_valid  out  1  head entry available; equals !empty.
- out_ready  in  1  consumer takes the head entry.
- out_result  out  16  head entry product.
- out_flags  out  3  head entry {exception, overflow, underflow}.
- sticky_flags  out  3  OR of every accepted flag set since the last clear.
- clr_sticky  in  1  synchronous clear of sticky_flags and all counters.
- cnt_total  out  CNT_W  accepted products.
- cnt_exception  out  CNT_W  accepted entries with the exception flag set.
- cnt_overflow  out  CNT_W  accepted entries with the overflow flag set.
- cnt_underflow  out  CNT_W  accepted entries with the underflow flag set.
- level  out  log2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (async, rst=1): pointers = 0, level = 0, out_valid = 0, in_ready = 1, sticky_flags = 0, all counters = 0. out_result and out_flags read as 0 while empty. Storage contents are don't-care.
- Push occurs when in_valid && in_ready. The entry {in_result, exception, overflow, underflow} is written at the write pointer, and the write pointer increments modulo DEPTH.
- Pop occurs when out_valid && out_ready; the read pointer increments modulo DEPTH.
- out_result and out_flags are combinational reads of the entry at the read pointer.
- Latency: an entry pushed on edge N appears on out_* after edge N (zero bubble). There is no pass-through while empty.
- Level update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged; both pointers advance.
- Full (level == DEPTH): in_ready = 0, so in_valid is ignored. A pop on that edge frees a slot that is visible on the next cycle.
- Empty (level == 0): out_valid = 0; out_ready is ignored.
- Pointer wrap: log2(DEPTH)-bit pointers wrap naturally. Full and empty are determined by level, not by pointer compare.
- Sticky flags: on each push, sticky_flags |= the three entry flags. Flags on non-accepted cycles are ignored.
- Counters: on each push, cnt_total +1 and each flagged counter +1. Every counter saturates at 2^CNT_W-1 and never wraps.
- clr_sticky on the same edge as a push: the clear wins for sticky_flags and counters. The pushed entry is still stored in the FIFO.
- clr_sticky does not affect FIFO contents, pointers or level.
- Reset asserted mid-stream discards all queued entries immediately. The first push after deassertion lands in slot 0.

Test Plan:
- Reset, then push 0x4400/000, 0x5100/000, 0xC800/100 with out_ready=0 -> level=3, out_result=0x4400, cnt_total=3, cnt_exception=1, sticky_flags=100.
- Fill to 4 entries, hold in_valid=1 with 0x1234 -> in_ready=0, level stays 4. Pop one -> in_ready=1 next cycle, then 0x1234 is stored as entry 5.
- Continuous push and pop of 10 entries 0x0001..0x000A -> out sequence 0x0001..0x000A in order, level stays 1, pointers wrap twice.
- Push 0x7C00/110 and 0x0000/101, then assert clr_sticky together with a push of 0x3C00/010 -> sticky_flags=000 and all counters 0 after that edge, FIFO holds 3 entries.
- Force counters to 0xFFFF using CNT_W=16 and 65,540 pushes with overflow=1 -> cnt_overflow stays at 0xFFFF.
- Assert rst while level=3 -> out_valid=0, level=0, counters=0 asynchronously. After release, push 0xABCD -> out_result=0xABCD.
